bp_lce_cmd_buffer: RTL

// - Ingress buffer between the coherence-network command channel and an LCE's command input.
// - Upstream side: ready_and handshake. Downstream side: valid->yumi handshake, which is
//   the contract the LCE command input expects.
// - Decouples network back-pressure from LCE processing stalls (tag/data/stat mem contention).
// - Stores header + block data per entry; strict FIFO order; no bypass.

---
 rtl/bp_lce_cmd_buffer.sv | 85 ++++++++
 1 files changed

// File: rtl/bp_lce_cmd_buffer.sv
// Ingress command buffer between the coherence network and an LCE command input.
// Strict FIFO of {header, data}; ready_and on the network side, valid->yumi toward the LCE.
module bp_lce_cmd_buffer #(
  parameter int unsigned lce_cmd_header_width_lp = 32,
  parameter int unsigned cce_block_width_p       = 64,
  parameter int unsigned els_p                   = 2,
  localparam int unsigned lg_els_lp              = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [lce_cmd_header_width_lp-1:0] lce_cmd_header_i,
  input  logic [cce_block_width_p-1:0]       lce_cmd_data_i,
  input  logic                               lce_cmd_v_i,
  output logic                               lce_cmd_ready_and_o,
  output logic [lce_cmd_header_width_lp-1:0] lce_cmd_header_o,
  output logic [cce_block_width_p-1:0]       lce_cmd_data_o,
  output logic                               lce_cmd_v_o,
  input  logic                               lce_cmd_yumi_i,
  output logic [lg_els_lp:0]                 count_o,
  output logic                               empty_o
);

  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $fatal(1, "bp_lce_cmd_buffer: els_p must be a power of two >= 2");
  end

  logic [lce_cmd_header_width_lp-1:0] hdr_mem_q  [els_p];
  logic [cce_block_width_p-1:0]       data_mem_q [els_p];

  logic [lg_els_lp-1:0] rptr_q, rptr_d;
  logic [lg_els_lp-1:0] wptr_q, wptr_d;
  logic [lg_els_lp:0]   count_q, count_d;

  logic full, empty, enq, deq;

  // Occupancy decides full/empty; pointers alone are ambiguous when they match.
  assign full  = (count_q == (lg_els_lp + 1)'(els_p));
  assign empty = (count_q == '0);

  assign lce_cmd_ready_and_o = ~reset_i & ~full;
  assign lce_cmd_v_o         = ~empty;
  assign count_o             = count_q;
  assign empty_o             = empty;

  assign enq = lce_cmd_v_i & lce_cmd_ready_and_o;
  assign deq = lce_cmd_yumi_i;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (enq) wptr_d = wptr_q + 1'b1;
    if (deq) rptr_d = rptr_q + 1'b1;
    if (enq & ~deq)      count_d = count_q + 1'b1;
    else if (~enq & deq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      hdr_mem_q[wptr_q]  <= lce_cmd_header_i;
      data_mem_q[wptr_q] <= lce_cmd_data_i;
    end
  end

  assign lce_cmd_header_o = hdr_mem_q[rptr_q];
  assign lce_cmd_data_o   = data_mem_q[rptr_q];

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) lce_cmd_yumi_i |-> lce_cmd_v_o
  ) else $error("bp_lce_cmd_buffer: yumi asserted with no valid head entry");

endmodule
